mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus initiator that drives the data-memory interface (mem_read, mem_write, address, write_data / read_data) to move blocks of words without the core.
- Supports two modes:
  - Copy: memory to memory, overlap-safe.
  - Fill: writes a constant pattern.
- Sits beside the MEM stage and shares the data-memory port through an external mux, selected by busy.
- Memory model assumed by this block: word-addressed, 0..DEPTH-1, combinational read, write on clk rising edge.

Parameters:
- DEPTH, 1024, number of addressable words in data memory.
- LEN_W, 11, width of the length field (covers 0..DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src  in  32  source word address (ignored in fill).
- dst  in  32  destination word address.
- len  in  LEN_W  number of words.
- pattern  in  32  fill value.
- busy  out  1  high in READ/WRITE.
- done  out  1  one-cycle completion pulse.
- error  out  1  range error flag; sticky until the next accepted start.
- mem_read  out  1  read strobe to data memory.
- mem_write  out  1  write strobe to data memory.
- address  out  32  memory address.
- write_data  out  32  memory write data.
- read_data  in  32  memory read data (combinational).

Behaviour:
- Reset (rst=0, any time, async):
  - State becomes IDLE.
  - busy, done, error, mem_read and mem_write are 0; address and write_data are 0.
  - Internal cursors, count and buffer are cleared.
  - Strobes are decoded from state only, so a reset mid-transfer kills mem_write the same cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1 at edge E0:
  - Latch mode, src, dst, len and pattern. Clear error.
  - Range check uses 33-bit sums. Error if dst+len > DEPTH, or if mode=0 and src+len > DEPTH.
  - On range error: set error=1 and go to DONE; no memory access occurs.
  - If len==0: go to DONE with error=0.
  - Otherwise go to READ (copy) or WRITE (fill), with remaining=len.
- Direction: descending iff mode=0 && dst>src && dst<src+len; otherwise ascending.
  - Ascending: cursors start at src and dst.
  - Descending: cursors start at src+len-1 and dst+len-1.
- READ:
  - mem_read=1, address=src_cur.
  - At the edge, buffer<=read_data, then go to WRITE.
- WRITE:
  - mem_write=1, address=dst_cur, write_data = buffer (copy) or pattern (fill).
  - At the edge, remaining-=1 and cursors step ±1.
  - If remaining was 1, go to DONE; else go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency from E0 to the done cycle:
  - Copy: 2N+1 cycles.
  - Fill: N+1 cycles.
  - Zero-length or error: 1 cycle.
- Outputs outside READ/WRITE: both strobes 0, address=0, write_data=0.
- start while busy or in DONE is ignored; it is not queued.
- Input changes after E0 have no effect (inputs are latched).

Decomposition:
- Shared package mem_copy_pkg holds:
  - state typedef (IDLE/READ/WRITE/DONE);
  - DEPTH_DEFAULT constant;
  - MODE_COPY and MODE_FILL constants.
- One natural sub-module, range_check (combinational): produces the error and descending flags from src, dst, len and mode.
- FSM and datapath stay in mem_copy_engine.

Test Plan:
- Memory preloaded mem[k]=k for k<10; copy src=0, dst=20, len=4 -> mem[20..23]=0,1,2,3; done exactly 9 cycles after E0; busy high for 8 cycles.
- Overlapping copy src=2, dst=4, len=5 -> descending order, first write address 8; final mem[4..8]=2,3,4,5,6.
- Fill dst=100, len=3, pattern=32'hDEADBEEF -> mem[100..102]=DEADBEEF; no mem_read ever asserted; done 4 cycles after E0.
- Copy src=1020, len=8 -> error=1 and done in the cycle after E0; zero mem strobes; error stays 1 until a later valid start clears it.
- len=0 -> done next cycle, error=0; start pulsed again while busy during a len=4 copy -> ignored, only one done pulse.
- rst driven 0 mid-copy (after 2 words) -> mem_write drops immediately, all outputs 0; mem[22..23] untouched; a fresh start then works normally.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the block copy / fill engine.
// State encoding, default memory depth and mode codes.
package mem_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int   DEPTH_DEFAULT = 1024;
    localparam logic MODE_COPY     = 1'b0;
    localparam logic MODE_FILL     = 1'b1;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Request/status handshake plus data-memory port of the copy engine.
// The engine is the master of the memory port; the slave side is core + memory.
interface mem_copy_if #(
    parameter int LEN_W = 11
);
    logic             start;
    logic             mode;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;
    logic             busy;
    logic             done;
    logic             error;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic [31:0]      read_data;

    modport master (
        input  start, mode, src, dst, len, pattern, read_data,
        output busy, done, error, mem_read, mem_write, address, write_data
    );

    modport slave (
        output start, mode, src, dst, len, pattern, read_data,
        input  busy, done, error, mem_read, mem_write, address, write_data
    );
endinterface

// File: rtl/mem_copy_engine_range_check.sv
// Combinational request qualification: out-of-range detection and
// copy direction (descending when the destination overlaps above the source).
module range_check
    import mem_copy_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LEN_W = 11
) (
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             range_err,
    output logic             descending
);
    logic [32:0] src_end;
    logic [32:0] dst_end;

    // 33-bit sums so a source/destination near 2^32 cannot wrap into range
    assign src_end = {1'b0, src} + 33'(len);
    assign dst_end = {1'b0, dst} + 33'(len);

    assign range_err  = (dst_end > 33'(DEPTH)) ||
                        ((mode == MODE_COPY) && (src_end > 33'(DEPTH)));
    assign descending = (mode == MODE_COPY) && (dst > src) && ({1'b0, dst} < src_end);
endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / fill engine driving the data-memory port while busy.
// Copy alternates READ/WRITE per word; fill streams WRITE cycles only.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LEN_W = 11
) (
    input  logic     clk,
    input  logic     rst,
    mem_copy_if.master bus
);
    state_t           state_reg,     state_next;
    logic             mode_reg,      mode_next;
    logic             desc_reg,      desc_next;
    logic             error_reg,     error_next;
    logic [31:0]      src_cur_reg,   src_cur_next;
    logic [31:0]      dst_cur_reg,   dst_cur_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [31:0]      pattern_reg,   pattern_next;
    logic [31:0]      buffer_reg,    buffer_next;

    logic        range_err;
    logic        descending;
    logic        busy, done, mem_read, mem_write;
    logic [31:0] address, write_data;

    range_check #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_range_check (
        .mode       (bus.mode),
        .src        (bus.src),
        .dst        (bus.dst),
        .len        (bus.len),
        .range_err  (range_err),
        .descending (descending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_COPY;
            desc_reg      <= 1'b0;
            error_reg     <= 1'b0;
            src_cur_reg   <= '0;
            dst_cur_reg   <= '0;
            remaining_reg <= '0;
            pattern_reg   <= '0;
            buffer_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            desc_reg      <= desc_next;
            error_reg     <= error_next;
            src_cur_reg   <= src_cur_next;
            dst_cur_reg   <= dst_cur_next;
            remaining_reg <= remaining_next;
            pattern_reg   <= pattern_next;
            buffer_reg    <= buffer_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        desc_next      = desc_reg;
        error_next     = error_reg;
        src_cur_next   = src_cur_reg;
        dst_cur_next   = dst_cur_reg;
        remaining_next = remaining_reg;
        pattern_next   = pattern_reg;
        buffer_next    = buffer_reg;
        busy           = 1'b0;
        done           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        address        = '0;
        write_data     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_next      = bus.mode;
                    pattern_next   = bus.pattern;
                    desc_next      = descending;
                    remaining_next = bus.len;
                    error_next     = range_err;
                    // Descending cursors start at the last word of each block
                    src_cur_next   = descending ? bus.src + 32'(bus.len) - 32'd1 : bus.src;
                    dst_cur_next   = descending ? bus.dst + 32'(bus.len) - 32'd1 : bus.dst;
                    if (range_err || (bus.len == '0))
                        state_next = ST_DONE;
                    else if (bus.mode == MODE_FILL)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                address     = src_cur_reg;
                buffer_next = bus.read_data;
                state_next  = ST_WRITE;
            end
            ST_WRITE: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                address        = dst_cur_reg;
                write_data     = (mode_reg == MODE_FILL) ? pattern_reg : buffer_reg;
                remaining_next = remaining_reg - 1'b1;
                src_cur_next   = desc_reg ? src_cur_reg - 32'd1 : src_cur_reg + 32'd1;
                dst_cur_next   = desc_reg ? dst_cur_reg - 32'd1 : dst_cur_reg + 32'd1;
                if (remaining_reg == LEN_W'(1))
                    state_next = ST_DONE;
                else if (mode_reg == MODE_FILL)
                    state_next = ST_WRITE;
                else
                    state_next = ST_READ;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error_reg;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.address    = address;
    assign bus.write_data = write_data;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: directed scenarios plus randomized transfers checked
// against a memmove/fill reference model with spec-derived timing.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LEN_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_copy_if #(.LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign bus.read_data = (bus.address < DEPTH) ? mem[bus.address[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (bus.mem_write && (bus.address < DEPTH))
            mem[bus.address[9:0]] <= bus.write_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int k = 0; k < DEPTH; k++)
            if (mem[k] !== ref_mem[k]) d++;
        return d;
    endfunction

    task automatic scramble_inputs();
        bus.mode    = 1'($urandom);
        bus.src     = $urandom;
        bus.dst     = $urandom;
        bus.len     = LEN_W'($urandom);
        bus.pattern = $urandom;
    endtask

    // Reference model: memmove or fill semantics, plus expected timing
    task automatic run_xfer(input logic m, input longint s, input longint d, input int n,
                            input logic [31:0] pat, input int poke_at);
        logic        exp_err;
        int          exp_lat, exp_reads, exp_writes, cycles, busy_cnt, reads, extra_done;
        longint      first_w, last_w;
        logic        done_seen;
        logic [31:0] tmp [$];
        logic [31:0] wq  [$];

        exp_err = (d + n > DEPTH) || (m == MODE_COPY && s + n > DEPTH);
        if (!exp_err && n > 0) begin
            if (m == MODE_COPY) begin
                for (int i = 0; i < n; i++) tmp.push_back(ref_mem[int'(s) + i]);
                for (int i = 0; i < n; i++) ref_mem[int'(d) + i] = tmp[i];
            end else begin
                for (int i = 0; i < n; i++) ref_mem[int'(d) + i] = pat;
            end
        end
        exp_lat    = (exp_err || n == 0) ? 1 : (m == MODE_COPY ? 2 * n + 1 : n + 1);
        exp_reads  = (!exp_err && m == MODE_COPY) ? n : 0;
        exp_writes = exp_err ? 0 : n;
        if (m == MODE_COPY && d > s && d < s + n) begin
            first_w = d + n - 1; last_w = d;
        end else begin
            first_w = d; last_w = d + n - 1;
        end

        @(negedge clk);
        bus.mode = m; bus.src = 32'(s); bus.dst = 32'(d); bus.len = LEN_W'(n); bus.pattern = pat;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs();

        cycles = 1; busy_cnt = 0; reads = 0; done_seen = 1'b0;
        while (1) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.mem_read) reads++;
            if (bus.mem_write) wq.push_back(bus.address);
            if (bus.done) begin done_seen = 1'b1; break; end
            if (cycles >= 4000) break;
            if (cycles == poke_at) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cycles++;
        end
        check("done_seen", 64'(done_seen), 64'd1);
        check("latency", 64'(cycles), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check("reads", 64'(reads), 64'(exp_reads));
        check("writes", 64'(wq.size()), 64'(exp_writes));
        check("error_at_done", 64'(bus.error), 64'(exp_err));
        if (wq.size() > 0 && exp_writes > 0) begin
            check("first_waddr", 64'(wq[0]), 64'(first_w));
            check("last_waddr", 64'(wq[wq.size()-1]), 64'(last_w));
        end
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("single_done", 64'(extra_done), 64'd0);
        check("error_sticky", 64'(bus.error), 64'(exp_err));
        check("mem_contents", 64'(mem_diff()), 64'd0);
        $display("xfer mode=%0d src=%0d dst=%0d len=%0d cycles=%0d writes=%0d err=%0d",
                 m, s, d, n, cycles, wq.size(), bus.error);
    endtask

    task automatic reset_mid_copy();
        int writes = 0;
        int guard  = 0;
        @(negedge clk);
        bus.mode = MODE_COPY; bus.src = 32'd0; bus.dst = 32'd20; bus.len = LEN_W'(4);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (guard < 100) begin
            @(negedge clk);
            if (bus.mem_write) begin
                if (writes == 2) break;
                writes++;
            end
            guard++;
        end
        check("rst_reached_3rd_write", 64'(writes), 64'd2);
        rst = 1'b0;
        #1;
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_strobes", 64'({bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write}), 64'd0);
        check("rst_addr_data", {bus.address, bus.write_data}, 64'd0);
        ref_mem[20] = ref_mem[0];
        ref_mem[21] = ref_mem[1];
        repeat (2) @(negedge clk);
        check("rst_mem_contents", 64'(mem_diff()), 64'd0);
        rst = 1'b1;
        $display("xfer reset mid-copy src=0 dst=20 len=4 writes_before_reset=%0d", writes);
    endtask

    initial begin
        longint rs, rd;
        int     rn;
        logic   rm;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.pattern = '0;
        for (int k = 0; k < DEPTH; k++) mem[k] = (k < 10) ? 32'(k) : $urandom;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = mem[k];

        repeat (3) @(negedge clk);
        check("reset_strobes", 64'({bus.busy, bus.done, bus.error, bus.mem_read, bus.mem_write}), 64'd0);
        check("reset_addr_data", {bus.address, bus.write_data}, 64'd0);
        rst = 1'b1;

        run_xfer(MODE_COPY, 0, 20, 4, 32'h0, -1);
        run_xfer(MODE_COPY, 2, 4, 5, 32'h0, -1);
        run_xfer(MODE_FILL, 0, 100, 3, 32'hDEADBEEF, -1);
        run_xfer(MODE_COPY, 1020, 0, 8, 32'h0, -1);
        run_xfer(MODE_COPY, 5, 30, 0, 32'h0, -1);
        run_xfer(MODE_COPY, 10, 40, 4, 32'h0, 3);
        run_xfer(MODE_COPY, 64'hFFFF_FFF0, 50, 32, 32'h0, -1);
        run_xfer(MODE_FILL, 0, 1000, 30, 32'h1234_5678, -1);
        run_xfer(MODE_COPY, 8, 6, 6, 32'h0, -1);

        reset_mid_copy();
        run_xfer(MODE_COPY, 0, 20, 4, 32'h0, -1);

        for (int t = 0; t < 20; t++) begin
            rm = 1'($urandom);
            rs = $urandom_range(0, 1010);
            rn = $urandom_range(0, 40);
            if ($urandom_range(0, 2) == 0) begin
                rd = rs + longint'($urandom_range(0, 20)) - 10;
                if (rd < 0) rd = 0;
            end else begin
                rd = $urandom_range(0, 1023);
            end
            run_xfer(rm, rs, rd, rn, $urandom, (t % 4 == 0) ? 2 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
